rtc_bus_cycle: RTL and testbench



---
 rtl/rtc_bus_pkg.sv | 79 +++++++
 rtl/phase_timer.sv | 25 ++
 rtl/rtc_bus_cycle.sv | 110 +++++++++++
 tb/tb_rtc_bus_cycle.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared state encoding, default bus timing and per-state pin decode for the
// RTC multiplexed-bus transaction engine.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    A_SU = 4'd1,
    A_ST = 4'd2,
    A_HD = 4'd3,
    A_GP = 4'd4,
    D_SU = 4'd5,
    D_ST = 4'd6,
    D_HD = 4'd7,
    D_GP = 4'd8
  } state_t;

  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_PULSE = 10;
  localparam int DEF_T_HOLD  = 2;
  localparam int DEF_T_GAP   = 5;

  // Strobe vector order is {ad, cs, rd, wr}, all active low.
  localparam logic [3:0] STROBE_IDLE = 4'b1111;

  typedef struct packed {
    logic [3:0] strobes;
    logic       oe;
    logic [7:0] bus;
  } drive_t;

  function automatic state_t next_phase(state_t s);
    case (s)
      IDLE:    next_phase = A_SU;
      A_SU:    next_phase = A_ST;
      A_ST:    next_phase = A_HD;
      A_HD:    next_phase = A_GP;
      A_GP:    next_phase = D_SU;
      D_SU:    next_phase = D_ST;
      D_ST:    next_phase = D_HD;
      D_HD:    next_phase = D_GP;
      default: next_phase = IDLE;
    endcase
  endfunction

  // Pin values held for the whole of state s; the address phase always uses
  // wr as its strobe, the data phase uses wr or rd depending on direction.
  function automatic drive_t bus_drive(state_t s, logic we, logic [7:0] addr,
                                       logic [7:0] wdata);
    drive_t d;
    d.strobes = STROBE_IDLE;
    d.oe      = 1'b0;
    d.bus     = 8'h00;
    case (s)
      A_SU, A_HD: begin
        d.strobes = 4'b0011;
        d.oe      = 1'b1;
        d.bus     = addr;
      end
      A_ST: begin
        d.strobes = 4'b0010;
        d.oe      = 1'b1;
        d.bus     = addr;
      end
      D_SU, D_HD: begin
        d.strobes = 4'b1011;
        d.oe      = we;
        d.bus     = we ? wdata : 8'h00;
      end
      D_ST: begin
        d.strobes = we ? 4'b1010 : 4'b1001;
        d.oe      = we;
        d.bus     = we ? wdata : 8'h00;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// 8-bit down counter that times one bus phase: load on state entry, then
// count down and hold at zero.
module phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] value,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= value;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// Runs one timed address phase plus data phase on the RTC's multiplexed
// Intel-mode bus per accepted request, capturing read data and pulsing done.
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_GAP   = DEF_T_GAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] ADout,
  output logic       oe,
  input  logic [7:0] ADin,
  output logic       ad,
  output logic       cs,
  output logic       rd,
  output logic       wr
);

  // Timer counts down to zero, so a state of N cycles loads N-1.
  localparam logic [7:0] LEN_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] LEN_PULSE = 8'(T_PULSE - 1);
  localparam logic [7:0] LEN_HOLD  = 8'(T_HOLD - 1);
  localparam logic [7:0] LEN_GAP   = 8'(T_GAP - 1);

  function automatic logic [7:0] phase_len(state_t s);
    case (s)
      A_SU, D_SU: phase_len = LEN_SETUP;
      A_ST, D_ST: phase_len = LEN_PULSE;
      A_HD, D_HD: phase_len = LEN_HOLD;
      A_GP, D_GP: phase_len = LEN_GAP;
      default:    phase_len = 8'd0;
    endcase
  endfunction

  state_t     state, state_n;
  logic       we_l, we_n;
  logic [7:0] addr_l, addr_n, wdata_l, wdata_n;
  logic       timer_zero, timer_load;
  logic [7:0] timer_val;
  drive_t     drv_n;

  phase_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .value (timer_val),
    .zero  (timer_zero)
  );

  // Pins are decoded from the next state so they change on the same edge as
  // the state register, keeping every bus output registered.
  always_comb begin
    state_n = state;
    we_n    = we_l;
    addr_n  = addr_l;
    wdata_n = wdata_l;
    if (state == IDLE) begin
      if (req) begin
        state_n = A_SU;
        we_n    = we;
        addr_n  = addr;
        wdata_n = wdata;
      end
    end else if (timer_zero) begin
      state_n = next_phase(state);
    end
    timer_load = (state_n != state);
    timer_val  = phase_len(state_n);
    drv_n      = bus_drive(state_n, we_n, addr_n, wdata_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      we_l            <= 1'b0;
      addr_l          <= 8'h00;
      wdata_l         <= 8'h00;
      {ad, cs, rd, wr} <= STROBE_IDLE;
      oe              <= 1'b0;
      ADout           <= 8'h00;
      busy            <= 1'b0;
      done            <= 1'b0;
      rdata           <= 8'h00;
    end else begin
      state           <= state_n;
      we_l            <= we_n;
      addr_l          <= addr_n;
      wdata_l         <= wdata_n;
      {ad, cs, rd, wr} <= drv_n.strobes;
      oe              <= drv_n.oe;
      ADout           <= drv_n.bus;
      busy            <= (state_n != IDLE);
      done            <= (state == D_GP) && (state_n == IDLE);
      if ((state == D_ST) && timer_zero && !we_l) begin
        rdata <= ADin;
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Directed bench for rtc_bus_cycle: a default-timing instance plus a
// minimum-timing instance sharing the same stimulus.
module tb_rtc_bus_cycle;

  logic       clk = 1'b0;
  logic       rst, req, we;
  logic [7:0] addr, wdata, ADin;

  logic       busy, done, oe, ad, cs, rd, wr;
  logic [7:0] rdata, ADout;
  logic       f_busy, f_done, f_oe, f_ad, f_cs, f_rd, f_wr;
  logic [7:0] f_rdata, f_ADout;

  int total = 0;
  int bad   = 0;

  int wr_low_addr, wr_low_data, rd_low, overlap, oe_rd, ad_no_cs;
  int addr_bad, addr_oe_bad, data_bad, read_oe;
  int done_cnt, done_c1, done_c2, done_busy, busy_cnt;
  logic [7:0] rdata_at_done;

  rtc_bus_cycle dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .ADout(ADout), .oe(oe),
    .ADin(ADin), .ad(ad), .cs(cs), .rd(rd), .wr(wr)
  );

  rtc_bus_cycle #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut_fast (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(f_busy), .done(f_done), .rdata(f_rdata), .ADout(f_ADout), .oe(f_oe),
    .ADin(ADin), .ad(f_ad), .cs(f_cs), .rd(f_rd), .wr(f_wr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents a request for one edge; hold keeps req high afterwards.
  task automatic apply_stimulus(input logic w, input logic [7:0] a,
                                input logic [7:0] d, input logic hold);
    we    = w;
    addr  = a;
    wdata = d;
    req   = 1'b1;
    tick();
    req = hold;
  endtask

  // Observes n cycles starting with the first busy cycle, modelling the RTC
  // by driving adin_val on ADin whenever rd is low.
  task automatic monitor(input int n, input bit fast, input bit hold,
                         input int glitch_at, input logic [7:0] glitch_addr,
                         input logic [7:0] exp_addr, input logic [7:0] exp_wdata,
                         input logic [7:0] adin_val);
    logic s_ad, s_cs, s_rd, s_wr, s_oe, s_busy, s_done;
    logic [7:0] s_bus, s_rdata;
    wr_low_addr = 0; wr_low_data = 0; rd_low = 0; overlap = 0; oe_rd = 0;
    ad_no_cs = 0; addr_bad = 0; addr_oe_bad = 0; data_bad = 0; read_oe = 0;
    done_cnt = 0; done_c1 = 0; done_c2 = 0; done_busy = 0; busy_cnt = 0;
    rdata_at_done = 8'h00;
    for (int c = 1; c <= n; c++) begin
      s_ad    = fast ? f_ad    : ad;
      s_cs    = fast ? f_cs    : cs;
      s_rd    = fast ? f_rd    : rd;
      s_wr    = fast ? f_wr    : wr;
      s_oe    = fast ? f_oe    : oe;
      s_busy  = fast ? f_busy  : busy;
      s_done  = fast ? f_done  : done;
      s_bus   = fast ? f_ADout : ADout;
      s_rdata = fast ? f_rdata : rdata;
      if (!s_wr && !s_ad) wr_low_addr++;
      if (!s_wr && s_ad) wr_low_data++;
      if (!s_wr && s_ad && s_bus != exp_wdata) data_bad++;
      if (!s_rd) rd_low++;
      if (!s_rd && !s_wr) overlap++;
      if (!s_rd && s_oe) oe_rd++;
      if (!s_ad && s_cs) ad_no_cs++;
      if (!s_ad && s_bus != exp_addr) addr_bad++;
      if (!s_ad && !s_oe) addr_oe_bad++;
      if (!s_cs && s_ad && s_oe) read_oe++;
      if (s_busy) busy_cnt++;
      if (s_done) begin
        done_cnt++;
        if (s_busy) done_busy++;
        if (done_cnt == 1) begin
          done_c1 = c;
          rdata_at_done = s_rdata;
        end else if (done_cnt == 2) begin
          done_c2 = c;
        end
        if (hold && done_cnt == 2) req = 1'b0;
      end
      ADin = !s_rd ? adin_val : 8'h00;
      if (c == glitch_at) begin
        req  = 1'b1;
        addr = glitch_addr;
      end else if (c == glitch_at + 1) begin
        req  = hold;
        addr = exp_addr;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00; ADin = 8'h00;
    tick();
    tick();
    check_output("reset strobes", {ad, cs, rd, wr}, 4'b1111);
    check_output("reset oe", oe, 1'b0);
    check_output("reset ADout", ADout, 8'h00);
    check_output("reset busy_done", {busy, done}, 2'b00);
    check_output("reset rdata", rdata, 8'h00);
    rst = 1'b0;
    tick();

    $display("[TB] write 0x45 to 0x22");
    apply_stimulus(1'b1, 8'h22, 8'h45, 1'b0);
    monitor(42, 1'b0, 1'b0, 0, 8'h00, 8'h22, 8'h45, 8'h00);
    check_output("wr addr-phase low cycles", wr_low_addr, 10);
    check_output("wr data-phase low cycles", wr_low_data, 10);
    check_output("write rd low cycles", rd_low, 0);
    check_output("write addr on bus", addr_bad + addr_oe_bad, 0);
    check_output("write data on bus", data_bad, 0);
    check_output("write ad without cs", ad_no_cs, 0);
    check_output("write busy cycles", busy_cnt, 38);
    check_output("write done count", done_cnt, 1);
    check_output("write done cycle", done_c1, 39);
    check_output("write busy at done", done_busy, 0);

    $display("[TB] read from 0x21");
    apply_stimulus(1'b0, 8'h21, 8'h00, 1'b0);
    monitor(42, 1'b0, 1'b0, 0, 8'h00, 8'h21, 8'h00, 8'h59);
    check_output("read rd low cycles", rd_low, 10);
    check_output("read wr data-phase", wr_low_data, 0);
    check_output("read oe in data phase", read_oe + oe_rd, 0);
    check_output("read done cycle", done_c1, 39);
    check_output("read rdata at done", rdata_at_done, 8'h59);

    $display("[TB] write after read keeps rdata");
    apply_stimulus(1'b1, 8'h10, 8'hAA, 1'b0);
    monitor(42, 1'b0, 1'b0, 0, 8'h00, 8'h10, 8'hAA, 8'h00);
    check_output("write keeps rdata", rdata, 8'h59);
    check_output("second write done cycle", done_c1, 39);

    $display("[TB] req while busy is ignored");
    apply_stimulus(1'b1, 8'h31, 8'h66, 1'b0);
    monitor(50, 1'b0, 1'b0, 5, 8'h77, 8'h31, 8'h66, 8'h00);
    check_output("glitch addr unchanged", addr_bad, 0);
    check_output("glitch done count", done_cnt, 1);
    check_output("glitch done cycle", done_c1, 39);

    $display("[TB] req held high back to back");
    apply_stimulus(1'b1, 8'h40, 8'h01, 1'b1);
    monitor(85, 1'b0, 1'b1, 0, 8'h00, 8'h40, 8'h01, 8'h00);
    check_output("b2b done count", done_cnt, 2);
    check_output("b2b first done", done_c1, 39);
    check_output("b2b second done", done_c2, 78);
    check_output("b2b busy cycles", busy_cnt, 76);

    $display("[TB] reset during read data strobe");
    apply_stimulus(1'b0, 8'h2B, 8'h00, 1'b0);
    monitor(25, 1'b0, 1'b0, 0, 8'h00, 8'h2B, 8'h00, 8'h3C);
    check_output("pre-reset rd low", rd, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midreset strobes", {ad, cs, rd, wr}, 4'b1111);
    check_output("midreset oe", oe, 1'b0);
    check_output("midreset busy_done", {busy, done}, 2'b00);
    check_output("midreset rdata", rdata, 8'h00);
    monitor(45, 1'b0, 1'b0, 0, 8'h00, 8'h2B, 8'h00, 8'h3C);
    check_output("post-reset no done", done_cnt, 0);
    check_output("post-reset not busy", busy_cnt, 0);
    apply_stimulus(1'b0, 8'h2B, 8'h00, 1'b0);
    monitor(42, 1'b0, 1'b0, 0, 8'h00, 8'h2B, 8'h00, 8'h3C);
    check_output("recovery done cycle", done_c1, 39);
    check_output("recovery rdata", rdata_at_done, 8'h3C);

    $display("[TB] minimum timing instance");
    for (int i = 0; i < 12; i++) tick();
    apply_stimulus(1'b1, 8'h55, 8'h99, 1'b0);
    monitor(12, 1'b1, 1'b0, 0, 8'h00, 8'h55, 8'h99, 8'h00);
    check_output("fast busy cycles", busy_cnt, 8);
    check_output("fast done cycle", done_c1, 9);
    check_output("fast wr addr low", wr_low_addr, 1);
    check_output("fast wr data low", wr_low_data, 1);
    check_output("fast write data", data_bad + addr_bad, 0);
    check_output("fast write overlap", overlap + rd_low, 0);
    apply_stimulus(1'b0, 8'h56, 8'h00, 1'b0);
    monitor(12, 1'b1, 1'b0, 0, 8'h00, 8'h56, 8'h00, 8'h7E);
    check_output("fast rd low", rd_low, 1);
    check_output("fast read wr addr low", wr_low_addr, 1);
    check_output("fast read overlap", overlap + oe_rd, 0);
    check_output("fast read done cycle", done_c1, 9);
    check_output("fast rdata", rdata_at_done, 8'h7E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
